apb_mem_sequencer: RTL and testbench

//  Converts single-cycle CPU data-memory requests (mem_read/mem_write from the control unit) into APB master transfers.

---
 rtl/apb_mem_sequencer.sv | 117 +++++++++++
 tb/tb_apb_mem_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_sequencer.sv
// CPU data-memory request to APB master sequencer (IDLE/SETUP/ACCESS/DONE), stalling the CPU per transfer.
// Optional ACCESS wait-state timeout enabled by defining APB_TIMEOUT_EN.
module apb_mem_sequencer #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic              err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t state, state_nxt;
   logic   req;
   logic   timeout;

   assign req = mem_read | mem_write;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if (state == SETUP)
         wait_cnt <= '0;
      else if (state == ACCESS && !pready)
         wait_cnt <= wait_cnt + 1'b1;
   end

   // Limit is hit on the cycle whose pready-low sample would make the count reach TIMEOUT_CYCLES.
   assign timeout = (state == ACCESS) && !pready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               stall     = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            psel      = 1'b1;
            stall     = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            stall   = 1'b1;
            if (pready || timeout)
               state_nxt = DONE;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         paddr  <= '0;
         pwdata <= '0;
         pwrite <= 1'b0;
         rdata  <= '0;
         err    <= 1'b0;
      end else begin
         if (state == IDLE && req) begin
            paddr  <= addr;
            pwdata <= wdata;
            pwrite <= mem_write;
         end
         if (state == ACCESS) begin
            if (pready) begin
               if (!pwrite)
                  rdata <= prdata;
               err <= pslverr;
            end else if (timeout) begin
               if (!pwrite)
                  rdata <= '0;
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_mem_sequencer.sv
// Randomized self-checking bench for apb_mem_sequencer: per-cycle trace derived from transaction latency rules.
module tb_apb_mem_sequencer;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_read, mem_write;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          stall, err, psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata;
   logic          pready, pslverr;

   apb_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Architectural state the bench tracks across transfers
   logic [AW-1:0] m_paddr;
   logic [DW-1:0] m_pwdata, m_rdata;
   logic          m_pwrite, m_err;

   logic          exp_valid = 1'b0;
   logic          e_stall, e_psel, e_pen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_valid) begin
         chk("stall",   32'(stall),   32'(e_stall));
         chk("psel",    32'(psel),    32'(e_psel));
         chk("penable", 32'(penable), 32'(e_pen));
         chk("paddr",   32'(paddr),   32'(m_paddr));
         chk("pwdata",  32'(pwdata),  32'(m_pwdata));
         chk("pwrite",  32'(pwrite),  32'(m_pwrite));
         chk("rdata",   32'(rdata),   32'(m_rdata));
         chk("err",     32'(err),     32'(m_err));
      end
   end

   task automatic model_reset();
      m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_rdata = '0; m_err = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         @(posedge clk); #1;
         mem_read = 1'b0; mem_write = 1'b0;
         addr = AW'($urandom); wdata = DW'($urandom);
         pready = 1'($urandom); prdata = DW'($urandom); pslverr = 1'($urandom);
         e_stall = 1'b0; e_psel = 1'b0; e_pen = 1'b0;
      end
   endtask

   // One transfer: cycle 0 = request sample, 1 = setup, 2..acc+1 = access, acc+2 = completion.
   task automatic txn(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int unsigned waits,
                      input logic [DW-1:0] rdv, input logic serr, input logic hold,
                      output int unsigned n_stall, output int unsigned n_psel,
                      output int unsigned n_pen);
      int unsigned acc;
      logic        tmo;
      tmo = 1'b0;
      acc = waits + 1;
`ifdef APB_TIMEOUT_EN
      if (waits >= TO) begin
         tmo = 1'b1;
         acc = TO;
      end
`endif
      n_stall = 0; n_psel = 0; n_pen = 0;
      for (int unsigned i = 0; i < acc + 3; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            mem_read = rd; mem_write = wr; addr = a; wdata = wd;
         end else begin
            mem_read = 1'($urandom); mem_write = 1'($urandom);
            addr = AW'($urandom); wdata = DW'($urandom);
         end
         if (i == acc + 2 && hold) begin
            mem_read = 1'b1; mem_write = 1'b0;
         end
         pready = 1'($urandom); prdata = DW'($urandom); pslverr = 1'($urandom);
         if (i >= 2 && i <= acc + 1) begin
            pready = ((i - 2) == waits);
            if (pready) begin
               prdata = rdv; pslverr = serr;
            end
         end
         if (i == 1) begin
            m_paddr = a; m_pwdata = wd; m_pwrite = wr;
         end
         if (i == acc + 2) begin
            if (tmo) begin
               m_err = 1'b1;
               if (!wr) m_rdata = '0;
            end else begin
               m_err = serr;
               if (!wr) m_rdata = rdv;
            end
         end
         e_stall = (i <= acc + 1);
         e_psel  = (i >= 1 && i <= acc + 1);
         e_pen   = (i >= 2 && i <= acc + 1);
         @(negedge clk);
         if (stall)   n_stall++;
         if (psel)    n_psel++;
         if (penable) n_pen++;
      end
   endtask

   int unsigned ns, np, ne;

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      chk("reset_psel",  32'(psel),  32'h0);
      chk("reset_stall", 32'(stall), 32'h0);
      chk("reset_rdata", 32'(rdata), 32'h0);
      chk("reset_paddr", 32'(paddr), 32'h0);
      chk("reset_err",   32'(err),   32'h0);
      rst = 1'b0;
      e_stall = 1'b0; e_psel = 1'b0; e_pen = 1'b0;
      exp_valid = 1'b1;
      idle(2);

      // Zero-wait read
      txn(1'b1, 1'b0, 8'h10, 16'h0000, 0, 16'hBEEF, 1'b0, 1'b0, ns, np, ne);
      chk("rd0_stall_cycles", 32'(ns), 32'd3);
      chk("rd0_psel_cycles",  32'(np), 32'd2);
      chk("rd0_pen_cycles",   32'(ne), 32'd1);
      chk("rd0_rdata",        32'(rdata), 32'hBEEF);
      chk("rd0_err",          32'(err), 32'h0);
      idle(1);

      // Write with three wait states
      txn(1'b0, 1'b1, 8'h22, 16'h1234, 3, 16'h5555, 1'b0, 1'b0, ns, np, ne);
      chk("wr3_stall_cycles", 32'(ns), 32'd6);
      chk("wr3_psel_cycles",  32'(np), 32'd5);
      chk("wr3_paddr",        32'(paddr), 32'h22);
      chk("wr3_pwdata",       32'(pwdata), 32'h1234);
      chk("wr3_rdata_kept",   32'(rdata), 32'hBEEF);
      idle(1);

      // Both requests with slave error, then a clean read clears err
      txn(1'b1, 1'b1, 8'h40, 16'hA5A5, 1, 16'h7777, 1'b1, 1'b0, ns, np, ne);
      chk("both_pwrite", 32'(pwrite), 32'h1);
      chk("both_err",    32'(err),    32'h1);
      txn(1'b1, 1'b0, 8'h41, 16'h0000, 0, 16'h0F0F, 1'b0, 1'b0, ns, np, ne);
      chk("clean_err",   32'(err),   32'h0);
      chk("clean_rdata", 32'(rdata), 32'h0F0F);

      // Back-to-back with the request held through completion
      txn(1'b1, 1'b0, 8'h50, 16'h0000, 0, 16'h1111, 1'b0, 1'b1, ns, np, ne);
      txn(1'b1, 1'b0, 8'h51, 16'h0000, 0, 16'h2222, 1'b0, 1'b0, ns, np, ne);
      chk("b2b_rdata", 32'(rdata), 32'h2222);

`ifdef APB_TIMEOUT_EN
      txn(1'b1, 1'b0, 8'h60, 16'h0000, 9, 16'h3333, 1'b0, 1'b0, ns, np, ne);
      chk("tmo_pen_cycles", 32'(ne), 32'd4);
      chk("tmo_err",        32'(err), 32'h1);
      chk("tmo_rdata",      32'(rdata), 32'h0);
      chk("tmo_stall",      32'(stall), 32'h0);
`endif

      // Asynchronous reset in the middle of ACCESS
      exp_valid = 1'b0;
      @(posedge clk); #1;
      mem_read = 1'b1; mem_write = 1'b0; addr = 8'h33; pready = 1'b0;
      @(posedge clk); #1;
      mem_read = 1'b0;
      @(posedge clk); #1;
      chk("rst_pre_penable", 32'(penable), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("rst_psel",    32'(psel),    32'h0);
      chk("rst_penable", 32'(penable), 32'h0);
      chk("rst_stall",   32'(stall),   32'h0);
      chk("rst_paddr",   32'(paddr),   32'h0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      e_stall = 1'b0; e_psel = 1'b0; e_pen = 1'b0;
      exp_valid = 1'b1;
      idle(2);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         int unsigned kind, w;
         logic rd, wr;
         kind = $urandom_range(2, 0);
         rd = (kind != 1);
         wr = (kind != 0);
`ifdef APB_TIMEOUT_EN
         w = $urandom_range(TO + 2, 0);
`else
         w = $urandom_range(4, 0);
`endif
         txn(rd, wr, AW'($urandom), DW'($urandom), w, DW'($urandom), 1'($urandom),
             1'($urandom), ns, np, ne);
         idle($urandom_range(2, 0));
      end

      idle(2);
      exp_valid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
